// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared cache package for the cacheline adaptor
//
// Purpose: beat geometry constants, the adaptor FSM state type and the
//          line-alignment helper shared by the cache memory-side blocks.
// Contents:
//   BEATS, BEAT_W, LINE_W  beats per line, beat width, line width
//   state_t                IDLE / RD_BURST / WR_BURST / DONE
//   line_align()           clears the byte-offset bits of a 32-bit address
package cacheline_adaptor_pkg;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 64;
  localparam int LINE_W = BEATS * BEAT_W;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  // A 256-bit line spans 32 bytes, so the low 5 address bits are the offset.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:5], 5'b0};
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - cacheline <-> memory burst adaptor
//
// Purpose: turns one cacheline read/write request into a 4-beat memory
//          burst and pulses resp_o once the burst completes.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   line_i            cacheline to write back (sampled on write accept only)
//   line_o            last cacheline filled from memory
//   address_i         request address; address_o is its line-aligned copy
//   read_i, write_i   cache requests, held until resp_o
//   resp_o            one-cycle completion pulse to the cache
//   burst_i, burst_o  memory read beat / memory write beat
//   read_o, write_o   memory burst requests, high for the whole burst
//   resp_i            memory per-beat acknowledge
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W = cacheline_adaptor_pkg::LINE_W,
  parameter int BEAT_W = cacheline_adaptor_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [LINE_W-1:0] buffer;
  logic [LINE_W-1:0] fill_line;

  assign cnt_next = cnt + 1'b1;

  // The buffer with the current beat merged in; on the final read beat this
  // is the complete line, so line_o updates in the same edge as DONE entry.
  always_comb begin
    fill_line = buffer;
    fill_line[int'(cnt)*BEAT_W +: BEAT_W] = burst_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      buffer    <= '0;
      line_o    <= '0;
      address_o <= '0;
      burst_o   <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          // Write wins when both requests are raised together.
          if (write_i) begin
            state     <= WR_BURST;
            write_o   <= 1'b1;
            address_o <= line_align(address_i);
            cnt       <= '0;
            buffer    <= line_i;
            burst_o   <= line_i[BEAT_W-1:0];
          end else if (read_i) begin
            state     <= RD_BURST;
            read_o    <= 1'b1;
            address_o <= line_align(address_i);
            cnt       <= '0;
          end
        end

        RD_BURST: begin
          if (resp_i) begin
            buffer[int'(cnt)*BEAT_W +: BEAT_W] <= burst_i;
            cnt <= cnt_next;
            if (cnt == LAST_BEAT) begin
              state  <= DONE;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              line_o <= fill_line;
            end
          end
        end

        WR_BURST: begin
          if (resp_i) begin
            cnt <= cnt_next;
            if (cnt == LAST_BEAT) begin
              state   <= DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              burst_o <= '0;
            end else begin
              // burst_o is registered, so preload the beat memory sees next.
              burst_o <= buffer[int'(cnt_next)*BEAT_W +: BEAT_W];
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
